// File: rtl/vx_dcache_req_arb_if.sv
// Request bundle for the dcache request arbiter.
// NUM_PORTS entries are flattened. On the arbiter input side, entry i*NUM_REQS+j is
// input i, lane j. On the output side, entry j is lane j.
interface vx_dcache_req_arb_if #(
    parameter int NUM_PORTS  = 4,
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 8,
    parameter int LSZ_W      = 2
);
    logic [NUM_PORTS-1:0]              valid;
    logic [NUM_PORTS-1:0]              rw;
    logic [NUM_PORTS*WORD_SIZE-1:0]    byteen;
    logic [NUM_PORTS*LSZ_W-1:0]        size;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr;
    logic [NUM_PORTS*8*WORD_SIZE-1:0]  data;
    logic [NUM_PORTS*TAG_WIDTH-1:0]    tag;
    logic [NUM_PORTS-1:0]              ready;

    modport master (output valid, rw, byteen, size, addr, data, tag, input ready);
    modport slave  (input valid, rw, byteen, size, addr, data, tag, output ready);
endinterface

// File: rtl/vx_dcache_req_arb.sv
// Per-lane round-robin arbiter that merges NUM_INPUTS dcache request masters into one
// NUM_REQS-lane bundle. The winning input index is appended in the tag LSBs so that
// responses can be routed back to the correct master.
// Optional feature: define VX_DCACHE_REQ_ARB_OUTBUF_EN to add a per-lane 2-entry skid
// buffer after the mux. This gives a latency of 1 and no combinational path from
// out_ready to in_ready. Without the macro, the path is purely combinational.
module vx_dcache_req_arb #(
    parameter int NUM_INPUTS   = 2,
    parameter int NUM_REQS     = 4,
    parameter int WORD_SIZE    = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int TAG_IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    vx_dcache_req_arb_if.slave  in_bus,
    vx_dcache_req_arb_if.master out_bus
);
    localparam int WORD_WIDTH    = 8 * WORD_SIZE;
    localparam int SEL_BITS      = $clog2(NUM_INPUTS);
    localparam int SEL_W         = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS;
    localparam int LSZ_W         = $clog2($clog2(WORD_SIZE) + 1);
    localparam int ENT_W         = 1 + WORD_SIZE + LSZ_W + ADDR_WIDTH + WORD_WIDTH + TAG_OUT_WIDTH;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [ENT_W-1:0] ent_t;

    sel_t                rr_ptr  [NUM_REQS];
    sel_t                winner  [NUM_REQS];
    ent_t                mux_ent [NUM_REQS];
    ent_t                out_ent [NUM_REQS];
    logic [NUM_REQS-1:0] any_valid;
    logic [NUM_REQS-1:0] lane_can_accept;
    logic [NUM_REQS-1:0] lane_fire;
    logic [NUM_REQS-1:0] out_vld;

    // (base + step) mod NUM_INPUTS; explicit modulo so non-power-of-2 counts wrap correctly
    function automatic sel_t wrap_inc(sel_t base, int step);
        int sum;
        sum = int'(base) + step;
        return sel_t'(sum % NUM_INPUTS);
    endfunction

    // Round-robin search from rr_ptr, winner payload mux, and grant to the winner only
    always_comb begin
        int sel;
        sel          = 0;
        in_bus.ready = '0;
        for (int j = 0; j < NUM_REQS; j++) begin
            winner[j]    = rr_ptr[j];
            any_valid[j] = 1'b0;
            // Descending offsets: the last hit is the one closest to rr_ptr
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                if (in_bus.valid[int'(wrap_inc(rr_ptr[j], k)) * NUM_REQS + j]) begin
                    winner[j]    = wrap_inc(rr_ptr[j], k);
                    any_valid[j] = 1'b1;
                end
            end
            sel = int'(winner[j]) * NUM_REQS + j;
            mux_ent[j] = {in_bus.rw[sel],
                          in_bus.byteen[sel*WORD_SIZE +: WORD_SIZE],
                          in_bus.size[sel*LSZ_W +: LSZ_W],
                          in_bus.addr[sel*ADDR_WIDTH +: ADDR_WIDTH],
                          in_bus.data[sel*WORD_WIDTH +: WORD_WIDTH],
                          (TAG_OUT_WIDTH'(in_bus.tag[sel*TAG_IN_WIDTH +: TAG_IN_WIDTH]) << SEL_BITS)
                              | TAG_OUT_WIDTH'(winner[j])};
            lane_fire[j] = !reset && any_valid[j] && lane_can_accept[j];
            for (int i = 0; i < NUM_INPUTS; i++) begin
                in_bus.ready[i*NUM_REQS + j] = lane_fire[j] && (int'(winner[j]) == i);
            end
        end
    end

    // Move the lane pointer past the winner only on a handshake; hold on stall or idle
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_REQS; j++) begin
            if (reset)
                rr_ptr[j] <= '0;
            else if (lane_fire[j])
                rr_ptr[j] <= wrap_inc(winner[j], 1);
        end
    end

`ifndef VX_DCACHE_REQ_ARB_OUTBUF_EN
    // Pass-through: the winner drives the lane in the same cycle
    always_comb begin
        for (int j = 0; j < NUM_REQS; j++) begin
            lane_can_accept[j] = out_bus.ready[j];
            out_vld[j]         = !reset && any_valid[j];
            out_ent[j]         = mux_ent[j];
        end
    end
`else
    ent_t                ent0_p1 [NUM_REQS];
    ent_t                ent1_p1 [NUM_REQS];
    logic [1:0]          cnt_p1  [NUM_REQS];
    logic [NUM_REQS-1:0] lane_pop;

    // Accept depends only on occupancy, so out_ready never reaches in_ready combinationally
    always_comb begin
        for (int j = 0; j < NUM_REQS; j++) begin
            lane_can_accept[j] = (cnt_p1[j] != 2'd2);
            out_vld[j]         = !reset && (cnt_p1[j] != 2'd0);
            out_ent[j]         = ent0_p1[j];
            lane_pop[j]        = out_vld[j] && out_bus.ready[j];
        end
    end

    // Per-lane 2-entry FIFO: ent0 is the head and ent1 holds the second entry
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_REQS; j++) begin
            if (reset)
                cnt_p1[j] <= 2'd0;
            else
                cnt_p1[j] <= cnt_p1[j] + 2'(lane_fire[j]) - 2'(lane_pop[j]);
            case ({lane_fire[j], lane_pop[j]})
                2'b10: begin
                    if (cnt_p1[j] == 2'd0)
                        ent0_p1[j] <= mux_ent[j];
                    else
                        ent1_p1[j] <= mux_ent[j];
                end
                2'b01: ent0_p1[j] <= ent1_p1[j];
                // Push and pop together happen only with one entry held, so the new entry becomes the head
                2'b11: ent0_p1[j] <= mux_ent[j];
                default: ;
            endcase
        end
    end
`endif

    // Unpack the per-lane entries onto the output bundle
    always_comb begin
        for (int j = 0; j < NUM_REQS; j++) begin
            out_bus.valid[j] = out_vld[j];
            {out_bus.rw[j],
             out_bus.byteen[j*WORD_SIZE +: WORD_SIZE],
             out_bus.size[j*LSZ_W +: LSZ_W],
             out_bus.addr[j*ADDR_WIDTH +: ADDR_WIDTH],
             out_bus.data[j*WORD_WIDTH +: WORD_WIDTH],
             out_bus.tag[j*TAG_OUT_WIDTH +: TAG_OUT_WIDTH]} = out_ent[j];
        end
    end
endmodule

// File: tb/tb_vx_dcache_req_arb.sv
// Scoreboard bench for vx_dcache_req_arb. It uses a 2-input/4-lane instance (a) and a
// 3-input/2-lane instance (b). Expected output entries are queued per lane when
// stimulus is issued. A negedge monitor pops and compares them on every output handshake.
module tb_vx_dcache_req_arb;
    localparam int NA = 2, NR_A = 4, NB = 3, NR_B = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
        logic [1:0]  size;
        logic        rw;
        logic [9:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vx_dcache_req_arb_if #(.NUM_PORTS(NA*NR_A), .WORD_SIZE(4), .ADDR_WIDTH(32), .TAG_WIDTH(8),  .LSZ_W(2)) ia ();
    vx_dcache_req_arb_if #(.NUM_PORTS(NR_A),    .WORD_SIZE(4), .ADDR_WIDTH(32), .TAG_WIDTH(9),  .LSZ_W(2)) oa ();
    vx_dcache_req_arb_if #(.NUM_PORTS(NB*NR_B), .WORD_SIZE(4), .ADDR_WIDTH(32), .TAG_WIDTH(8),  .LSZ_W(2)) ib ();
    vx_dcache_req_arb_if #(.NUM_PORTS(NR_B),    .WORD_SIZE(4), .ADDR_WIDTH(32), .TAG_WIDTH(10), .LSZ_W(2)) ob ();

    vx_dcache_req_arb #(.NUM_INPUTS(NA), .NUM_REQS(NR_A), .WORD_SIZE(4), .ADDR_WIDTH(32), .TAG_IN_WIDTH(8))
        dut_a (.clk(clk), .reset(reset), .in_bus(ia), .out_bus(oa));
    vx_dcache_req_arb #(.NUM_INPUTS(NB), .NUM_REQS(NR_B), .WORD_SIZE(4), .ADDR_WIDTH(32), .TAG_IN_WIDTH(8))
        dut_b (.clk(clk), .reset(reset), .in_bus(ib), .out_bus(ob));

    int   n_cmp = 0;
    int   n_fail = 0;
    int   rem_a [NA][NR_A];
    int   seq_a [NA][NR_A];
    int   rem_b [NB][NR_B];
    int   seq_b [NB][NR_B];
    logic fa [NA][NR_A];
    logic fb [NB][NR_B];
    bit   ovr_a;
    exp_t exp_a [NR_A][$];
    exp_t exp_b [NR_B][$];
    exp_t mon_act, mon_exp;

    // Master payload for (instance d, input i, lane j, sequence s)
    function automatic exp_t mk(int d, int i, int j, int s);
        exp_t e;
        e.addr   = 32'h2000_0000 + 32'(d) * 32'h10_0000 + 32'(i) * 32'h1_0000 + 32'(j) * 32'h1000 + 32'(s) * 32'h10;
        e.data   = 32'hC0DE_0000 ^ (32'(i) << 24) ^ (32'(j) << 16) ^ 32'(s * 7 + 1);
        e.byteen = 4'(1 << ((i + j + s) % 4));
        e.size   = 2'((i + s) % 3);
        e.rw     = 1'((i + j + s) % 2);
        e.tag    = {2'b00, d[0], i[1:0], j[1:0], s[2:0]};
        if (d == 0 && i == 1 && j == 0 && ovr_a) begin
            e.addr = 32'h1000_0040; e.data = 32'hDEAD_BEEF; e.byteen = 4'b0011;
            e.size = 2'd1; e.rw = 1'b1; e.tag = 10'h05A;
        end
        return e;
    endfunction

    task automatic push_a(int i, int j, int s);
        exp_t e;
        e = mk(0, i, j, s);
        e.tag = {1'b0, e.tag[7:0], 1'(i)};
        exp_a[j].push_back(e);
    endtask

    task automatic push_b(int i, int j, int s);
        exp_t e;
        e = mk(1, i, j, s);
        e.tag = {e.tag[7:0], 2'(i)};
        exp_b[j].push_back(e);
    endtask

    task automatic drive();
        exp_t e;
        int x;
        for (int i = 0; i < NA; i++) for (int j = 0; j < NR_A; j++) begin
            x = i * NR_A + j; e = mk(0, i, j, seq_a[i][j]);
            ia.valid[x] = (rem_a[i][j] > 0); ia.rw[x] = e.rw;
            ia.byteen[x*4 +: 4] = e.byteen; ia.size[x*2 +: 2] = e.size;
            ia.addr[x*32 +: 32] = e.addr; ia.data[x*32 +: 32] = e.data; ia.tag[x*8 +: 8] = e.tag[7:0];
        end
        for (int i = 0; i < NB; i++) for (int j = 0; j < NR_B; j++) begin
            x = i * NR_B + j; e = mk(1, i, j, seq_b[i][j]);
            ib.valid[x] = (rem_b[i][j] > 0); ib.rw[x] = e.rw;
            ib.byteen[x*4 +: 4] = e.byteen; ib.size[x*2 +: 2] = e.size;
            ib.addr[x*32 +: 32] = e.addr; ib.data[x*32 +: 32] = e.data; ib.tag[x*8 +: 8] = e.tag[7:0];
        end
    endtask

    // One clock: sample handshakes mid-cycle, then advance masters that fired
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NA; i++) for (int j = 0; j < NR_A; j++)
            fa[i][j] = ia.valid[i*NR_A + j] & ia.ready[i*NR_A + j];
        for (int i = 0; i < NB; i++) for (int j = 0; j < NR_B; j++)
            fb[i][j] = ib.valid[i*NR_B + j] & ib.ready[i*NR_B + j];
        @(posedge clk); #1;
        for (int i = 0; i < NA; i++) for (int j = 0; j < NR_A; j++)
            if (fa[i][j]) begin rem_a[i][j]--; seq_a[i][j]++; end
        for (int i = 0; i < NB; i++) for (int j = 0; j < NR_B; j++)
            if (fb[i][j]) begin rem_b[i][j]--; seq_b[i][j]++; end
        drive();
    endtask

    function automatic bit busy();
        bit b = 0;
        for (int i = 0; i < NA; i++) for (int j = 0; j < NR_A; j++) if (rem_a[i][j] > 0) b = 1;
        for (int i = 0; i < NB; i++) for (int j = 0; j < NR_B; j++) if (rem_b[i][j] > 0) b = 1;
        return b;
    endfunction

    function automatic int qlen();
        int n = 0;
        for (int j = 0; j < NR_A; j++) n += exp_a[j].size();
        for (int j = 0; j < NR_B; j++) n += exp_b[j].size();
        return n;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic wait_idle(string nm);
        int c = 0;
        while (busy() && c < 100) begin step(); c++; end
        if (busy()) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_issue_timeout: requests pending after %0d cycles, required 0", nm, c);
        end
    endtask

    task automatic drain(string nm);
        int c = 0;
        while (qlen() > 0 && c < 100) begin step(); c++; end
        if (qlen() > 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_drain_timeout: %0d expected outputs never seen, required 0", nm, qlen());
        end
    endtask

    // Monitor: every output handshake pops and checks the lane's oldest expected entry
    always @(negedge clk) begin
        if (!reset) begin
            for (int j = 0; j < NR_A; j++) begin
                if (oa.valid[j] && oa.ready[j]) begin
                    mon_act = {oa.addr[j*32 +: 32], oa.data[j*32 +: 32], oa.byteen[j*4 +: 4],
                               oa.size[j*2 +: 2], oa.rw[j], 1'b0, oa.tag[j*9 +: 9]};
                    if (exp_a[j].size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL a_lane%0d_unexpected: got %h required no output", j, mon_act);
                    end else begin
                        mon_exp = exp_a[j].pop_front();
                        chk($sformatf("a_lane%0d_out", j), 128'(mon_act), 128'(mon_exp));
                    end
                end
            end
            for (int j = 0; j < NR_B; j++) begin
                if (ob.valid[j] && ob.ready[j]) begin
                    mon_act = {ob.addr[j*32 +: 32], ob.data[j*32 +: 32], ob.byteen[j*4 +: 4],
                               ob.size[j*2 +: 2], ob.rw[j], ob.tag[j*10 +: 10]};
                    if (exp_b[j].size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL b_lane%0d_unexpected: got %h required no output", j, mon_act);
                    end else begin
                        mon_exp = exp_b[j].pop_front();
                        chk($sformatf("b_lane%0d_out", j), 128'(mon_act), 128'(mon_exp));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1;
        ovr_a = 0;
        for (int i = 0; i < NA; i++) for (int j = 0; j < NR_A; j++) begin rem_a[i][j] = 0; seq_a[i][j] = 0; end
        for (int i = 0; i < NB; i++) for (int j = 0; j < NR_B; j++) begin rem_b[i][j] = 0; seq_b[i][j] = 0; end
        oa.ready = '0; ob.ready = '0;
        drive();

        // During reset, requests are presented but nothing is granted or output
        repeat (2) @(posedge clk);
        #1;
        rem_a[0][0] = 1; rem_a[1][1] = 1; rem_b[2][1] = 1;
        oa.ready = '1; ob.ready = '1;
        drive(); #1;
        chk("reset_in_ready_a", 128'(ia.ready), 128'(0));
        chk("reset_out_valid_a", 128'(oa.valid), 128'(0));
        chk("reset_in_ready_b", 128'(ib.ready), 128'(0));
        chk("reset_out_valid_b", 128'(ob.valid), 128'(0));
        rem_a[0][0] = 0; rem_a[1][1] = 0; rem_b[2][1] = 0;
        drive();
        @(posedge clk); #1;
        reset = 0;
        #1;
        chk("idle_in_ready_a", 128'(ia.ready), 128'(0));
        chk("idle_out_valid_a", 128'(oa.valid), 128'(0));
        chk("idle_in_ready_b", 128'(ib.ready), 128'(0));
        chk("idle_out_valid_b", 128'(ob.valid), 128'(0));

        // Lane 0, both inputs valid: grants alternate 0,1,0,1 starting from pointer 0
        s0 = seq_a[0][0]; s1 = seq_a[1][0];
        push_a(0, 0, s0); push_a(1, 0, s1); push_a(0, 0, s0 + 1); push_a(1, 0, s1 + 1);
        rem_a[0][0] = 2; rem_a[1][0] = 2;
        drive(); #1;
        chk("rr_first_grant_in0", 128'(ia.ready[0]), 128'(1));
        chk("rr_first_grant_in1", 128'(ia.ready[NR_A]), 128'(0));
        wait_idle("rr_lane0"); drain("rr_lane0");

        // Independent lanes: lane 0 grants input 0 while lane 1 grants input 1
        push_a(0, 0, seq_a[0][0]); push_a(1, 1, seq_a[1][1]);
        rem_a[0][0] = 1; rem_a[1][1] = 1;
        drive(); #1;
        chk("indep_lane0_in0_ready", 128'(ia.ready[0]), 128'(1));
        chk("indep_lane1_in1_ready", 128'(ia.ready[NR_A + 1]), 128'(1));
        wait_idle("indep"); drain("indep");

        // Stall on lane 0: pointer is 1 after the previous input-0 grant
        oa.ready[0] = 1'b0;
        s0 = seq_a[0][0]; s1 = seq_a[1][0];
        push_a(1, 0, s1); push_a(0, 0, s0); push_a(1, 0, s1 + 1); push_a(0, 0, s0 + 1);
        rem_a[0][0] = 2; rem_a[1][0] = 2;
        drive();
        for (int c = 0; c < 3; c++) begin
            #1;
`ifndef VX_DCACHE_REQ_ARB_OUTBUF_EN
            chk("stall_in0_ready", 128'(ia.ready[0]), 128'(0));
            chk("stall_in1_ready", 128'(ia.ready[NR_A]), 128'(0));
            chk("stall_out_valid", 128'(oa.valid[0]), 128'(1));
            chk("stall_winner", 128'(oa.tag[0]), 128'(1));
`else
            if (c == 2) begin
                chk("full_in0_ready", 128'(ia.ready[0]), 128'(0));
                chk("full_in1_ready", 128'(ia.ready[NR_A]), 128'(0));
                chk("full_out_valid", 128'(oa.valid[0]), 128'(1));
                chk("full_head_winner", 128'(oa.tag[0]), 128'(1));
            end
`endif
            step();
        end
`ifndef VX_DCACHE_REQ_ARB_OUTBUF_EN
        chk("stall_pending", 128'(rem_a[0][0] + rem_a[1][0]), 128'(4));
`else
        chk("stall_pending", 128'(rem_a[0][0] + rem_a[1][0]), 128'(2));
`endif
        oa.ready[0] = 1'b1;
        wait_idle("stall"); drain("stall");

        // Payload is forwarded bit-exact; tag 0x5A from input 1 becomes 0xB5
        ovr_a = 1;
        exp_a[0].push_back('{addr: 32'h1000_0040, data: 32'hDEAD_BEEF, byteen: 4'b0011,
                             size: 2'd1, rw: 1'b1, tag: 10'h0B5});
        rem_a[1][0] = 1;
        drive(); #1;
`ifndef VX_DCACHE_REQ_ARB_OUTBUF_EN
        chk("payload_same_cycle_valid", 128'(oa.valid[0]), 128'(1));
`else
        chk("payload_latency_valid", 128'(oa.valid[0]), 128'(0));
`endif
        wait_idle("payload"); drain("payload");
        ovr_a = 0;
        drive();

        // Three inputs: grant order 0,1,2,0,1,2 including the 2->0 wrap
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NB; i++) push_b(i, 0, seq_b[i][0] + k);
        for (int i = 0; i < NB; i++) rem_b[i][0] = 2;
        drive(); #1;
        chk("b_first_grant_in0", 128'(ib.ready[0]), 128'(1));
        chk("b_first_grant_in1", 128'(ib.ready[NR_B]), 128'(0));
        chk("b_first_grant_in2", 128'(ib.ready[2*NR_B]), 128'(0));
        wait_idle("rr3"); drain("rr3");

        // Reset during a transaction: the request is lost and the master re-presents it
        oa.ready[2] = 1'b0;
        rem_a[0][2] = 1;
        drive();
        step();
        reset = 1;
        #1;
        chk("midreset_in_ready", 128'(ia.ready[2]), 128'(0));
        chk("midreset_out_valid", 128'(oa.valid[2]), 128'(0));
        @(posedge clk); #1;
        reset = 0;
        rem_a[0][2] = 0;
        drive(); #1;
        chk("postreset_out_valid", 128'(oa.valid[2]), 128'(0));
        oa.ready[2] = 1'b1;
        push_a(0, 2, seq_a[0][2]);
        rem_a[0][2] = 1;
        drive();
        wait_idle("represent"); drain("represent");

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
